// File: rtl/irq_pkg.sv
// Shared constants and FSM encoding for the interrupt controller and the core's vector decode.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam int         NSRC_DEF        = 4;
    localparam int         VEC_W_DEF       = 10;
    localparam logic [9:0] VEC_BASE_DEF    = 10'h3F0;
    localparam int         STRIDE_LOG2_DEF = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line plus rising-edge detect.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised vectored interrupt controller with irq/ack/iret handshake to the core.
// Define IRQ_NEST_EN to allow higher-priority sources to preempt a running handler.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | no handler running, waiting for an enabled pending source
//  ST_REQ     | irq asserted for the latched grant, waiting for irq_ack
//  ST_SERVICE | handler(s) in service, waiting for iret (or preemption)
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int               NSRC        = NSRC_DEF,
    parameter int               VEC_W       = VEC_W_DEF,
    parameter logic [VEC_W-1:0] VEC_BASE    = VEC_W'(VEC_BASE_DEF),
    parameter int               STRIDE_LOG2 = STRIDE_LOG2_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  ie,
    input  logic             en_we,
    input  logic [NSRC-1:0]  en_wdata,
    input  logic             irq_ack,
    input  logic             iret,
    output logic             irq,
    output logic [VEC_W-1:0] irq_addr,
    output logic             busy,
    output logic [NSRC-1:0]  pending,
    output logic [NSRC-1:0]  en
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
        return VEC_BASE + (VEC_W'(idx) << STRIDE_LOG2);
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  req;
    logic [IDX_W-1:0] winner;
    logic [NSRC-1:0]  grant_mask;

    irq_state_t       state;
    irq_state_t       state_nxt;
    logic             irq_nxt;
    logic [VEC_W-1:0] addr_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_nxt;
    logic             ack_take;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (ie[g]),
            .rise  (rise[g])
        );
    end

    assign req        = pending & en;
    assign winner     = lowest_idx(req);
    assign grant_mask = NSRC'(1) << grant;

`ifdef IRQ_NEST_EN
    logic [NSRC-1:0] isr;
    logic [NSRC-1:0] isr_nxt;
    logic [NSRC-1:0] isr_low;
    logic [NSRC-1:0] isr_pop;
    logic            preempt;

    // Sources strictly below the lowest in-service bit may preempt it.
    assign isr_low = (isr & (~isr + NSRC'(1))) - NSRC'(1);
    assign isr_pop = isr & (isr - NSRC'(1));
    assign preempt = |(req & isr_low);
    assign busy    = |isr;
`else
    logic busy_q;
    logic busy_nxt;

    assign busy = busy_q;
`endif

    always_comb begin
        state_nxt = state;
        irq_nxt   = irq;
        addr_nxt  = irq_addr;
        grant_nxt = grant;
        ack_take  = 1'b0;
`ifdef IRQ_NEST_EN
        isr_nxt   = isr;
`else
        busy_nxt  = busy_q;
`endif
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_REQ;
                    irq_nxt   = 1'b1;
                    addr_nxt  = vec_of(winner);
                    grant_nxt = winner;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt = ST_SERVICE;
                    irq_nxt   = 1'b0;
                    ack_take  = 1'b1;
`ifdef IRQ_NEST_EN
                    isr_nxt   = isr | grant_mask;
`else
                    busy_nxt  = 1'b1;
`endif
                end else if (!en[grant]) begin
                    irq_nxt = 1'b0;
`ifdef IRQ_NEST_EN
                    state_nxt = (|isr) ? ST_SERVICE : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            ST_SERVICE: begin
`ifdef IRQ_NEST_EN
                if (iret) begin
                    isr_nxt = isr_pop;
                    if (isr_pop == '0) state_nxt = ST_IDLE;
                end else if (preempt) begin
                    state_nxt = ST_REQ;
                    irq_nxt   = 1'b1;
                    addr_nxt  = vec_of(winner);
                    grant_nxt = winner;
                end
`else
                if (iret) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            irq      <= 1'b0;
            irq_addr <= '0;
            grant    <= '0;
        end else begin
            state    <= state_nxt;
            irq      <= irq_nxt;
            irq_addr <= addr_nxt;
            grant    <= grant_nxt;
        end
    end

`ifdef IRQ_NEST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) isr <= '0;
        else        isr <= isr_nxt;
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= 1'b0;
        else        busy_q <= busy_nxt;
    end
`endif

    // A fresh edge on the acknowledged source wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(ack_take ? grant_mask : '0)) | rise;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     en <= '0;
        else if (en_we) en <= en_wdata;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: priority, enable masking, handshake, reset.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ie;
    logic       en_we;
    logic [3:0] en_wdata;
    logic       irq_ack;
    logic       iret;
    logic       irq;
    logic [9:0] irq_addr;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] en;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .ie       (ie),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .irq_ack  (irq_ack),
        .iret     (iret),
        .irq      (irq),
        .irq_addr (irq_addr),
        .busy     (busy),
        .pending  (pending),
        .en       (en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_en(input logic [3:0] m);
        en_we    = 1'b1;
        en_wdata = m;
        step(1);
        en_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_iret();
        iret = 1'b1;
        step(1);
        iret = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        ie       = 4'b0000;
        en_we    = 1'b0;
        en_wdata = 4'b0000;
        irq_ack  = 1'b0;
        iret     = 1'b0;

        // 1: reset
        step(3);
        chk("rst_irq", irq, 1'b0);
        chk("rst_addr", irq_addr, 10'h000);
        chk("rst_en", en, 4'b0000);
        chk("rst_pend", pending, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        step(1);
        chk("rel_irq", irq, 1'b0);

        // 2: single source 2
        write_en(4'b1111);
        chk("t2_en", en, 4'b1111);
        ie = 4'b0100;
        step(2);
        ie = 4'b0000;
        step(1);
        chk("t2_pend", pending, 4'b0100);
        chk("t2_irq_early", irq, 1'b0);
        step(1);
        chk("t2_irq", irq, 1'b1);
        chk("t2_addr", irq_addr, 10'h3F8);
        pulse_ack();
        chk("t2_ack_irq", irq, 1'b0);
        chk("t2_ack_pend", pending, 4'b0000);
        chk("t2_ack_busy", busy, 1'b1);
        pulse_iret();
        chk("t2_iret_busy", busy, 1'b0);
        irq_ack = 1'b1;
        iret    = 1'b1;
        step(1);
        irq_ack = 1'b0;
        iret    = 1'b0;
        chk("t2_stray_irq", irq, 1'b0);
        chk("t2_stray_busy", busy, 1'b0);

        // 3: simultaneous sources 1 and 3, held high
        ie = 4'b1010;
        step(3);
        chk("t3_pend", pending, 4'b1010);
        step(1);
        chk("t3_irq1", irq, 1'b1);
        chk("t3_addr1", irq_addr, 10'h3F4);
        pulse_ack();
        chk("t3_pend_after", pending, 4'b1000);
        chk("t3_svc_irq", irq, 1'b0);
        pulse_iret();
        chk("t3_busy0", busy, 1'b0);
        step(1);
        chk("t3_irq2", irq, 1'b1);
        chk("t3_addr2", irq_addr, 10'h3FC);
        pulse_ack();
        pulse_iret();
        step(3);
        chk("t3_held_pend", pending, 4'b0000);
        chk("t3_held_irq", irq, 1'b0);
        ie = 4'b0000;
        step(3);

        // 4: enable masking
        write_en(4'b0000);
        chk("t4_en0", en, 4'b0000);
        ie = 4'b0001;
        step(3);
        chk("t4_pend", pending, 4'b0001);
        step(2);
        chk("t4_masked_irq", irq, 1'b0);
        ie = 4'b0000;
        write_en(4'b0001);
        chk("t4_en_lag_irq", irq, 1'b0);
        step(1);
        chk("t4_irq", irq, 1'b1);
        chk("t4_addr", irq_addr, 10'h3F0);
        write_en(4'b0000);
        chk("t4_wd_lag_irq", irq, 1'b1);
        step(1);
        chk("t4_wd_irq", irq, 1'b0);
        chk("t4_wd_pend", pending, 4'b0001);
        write_en(4'b1111);
        step(1);
        chk("t4_re_irq", irq, 1'b1);
        chk("t4_re_addr", irq_addr, 10'h3F0);
        pulse_ack();
        pulse_iret();
        chk("t4_clean_pend", pending, 4'b0000);

        // 5: higher priority during service of source 3
        ie = 4'b1000;
        step(4);
        chk("t5_addr3", irq_addr, 10'h3FC);
        pulse_ack();
        chk("t5_busy", busy, 1'b1);
        ie = 4'b1001;
        step(4);
        chk("t5_pend0", pending, 4'b0001);
`ifdef IRQ_NEST_EN
        chk("t5_nest_irq", irq, 1'b1);
        chk("t5_nest_addr", irq_addr, 10'h3F0);
        pulse_ack();
        chk("t5_nest_ack_busy", busy, 1'b1);
        pulse_iret();
        chk("t5_nest_iret1_busy", busy, 1'b1);
        pulse_iret();
        chk("t5_nest_iret2_busy", busy, 1'b0);
`else
        chk("t5_flat_irq", irq, 1'b0);
        pulse_iret();
        chk("t5_flat_busy", busy, 1'b0);
        step(1);
        chk("t5_flat_irq0", irq, 1'b1);
        chk("t5_flat_addr0", irq_addr, 10'h3F0);
        pulse_ack();
        pulse_iret();
        chk("t5_flat_done", busy, 1'b0);
`endif
        ie = 4'b0000;
        step(3);

        // 6: edge on the acknowledged source, then reset mid-service
        ie = 4'b0010;
        step(4);
        chk("t6_addr1", irq_addr, 10'h3F4);
        ie = 4'b0000;
        step(3);
        ie = 4'b0010;
        step(2);
        pulse_ack();
        chk("t6_set_wins", pending, 4'b0010);
        chk("t6_svc_busy", busy, 1'b1);
        chk("t6_svc_irq", irq, 1'b0);
        pulse_iret();
        step(1);
        chk("t6_again_irq", irq, 1'b1);
        chk("t6_again_addr", irq_addr, 10'h3F4);
        pulse_ack();
        chk("t6_again_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("t6_rst_irq", irq, 1'b0);
        chk("t6_rst_addr", irq_addr, 10'h000);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_pend", pending, 4'b0000);
        chk("t6_rst_en", en, 4'b0000);
        step(2);
        reset = 1'b1;
        ie    = 4'b0000;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
